adc_sample_packer: RTL and testbench

ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

---
 rtl/nmr_pkg.sv | 16 +
 rtl/adc_sync_fifo.sv | 49 ++++
 rtl/adc_sample_packer.sv | 116 +++++++++++
 tb/tb_adc_sample_packer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nmr_pkg.sv
// Shared constants and scan-state encoding for the NMR acquisition datapath.
package nmr_pkg;
  localparam int ADC_W_DEFAULT      = 16;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction
endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is presented on o_data while o_valid.
module adc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_push_ok,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_push_ok = w_push;
  assign o_valid   = !w_empty;
  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/adc_sample_packer.sv
// Packs ADC samples pairwise into 2x-wide words and queues them for a ready/valid consumer.
//   state | meaning
//   IDLE  | waiting for a registered rising edge of ACQ_EN
//   ACQ   | accepting samples, pairing them into words
//   FLUSH | push a pending half-word, upper half zero
//   DONE  | SCAN_DONE high for this one cycle
module adc_sample_packer
  import nmr_pkg::*;
#(
  parameter int ADC_DATA_WIDTH   = ADC_W_DEFAULT,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEFAULT,
  parameter int WORD_COUNT_WIDTH = 32
) (
  input  logic                          ADC_CLK,
  input  logic                          RESET_N,
  input  logic                          ACQ_EN,
  input  logic [ADC_DATA_WIDTH-1:0]     ADC_DATA,
  input  logic                          ADC_DATA_VALID,
  output logic [2*ADC_DATA_WIDTH-1:0]   DOUT,
  output logic                          DOUT_VALID,
  input  logic                          DOUT_READY,
  output logic [WORD_COUNT_WIDTH-1:0]   WORD_COUNT,
  output logic                          OVERFLOW,
  output logic                          SCAN_DONE
);
  scan_state_t                   r_state;
  logic                          r_acq_d1;
  logic                          r_acq_d2;
  logic                          r_have_lo;
  logic [ADC_DATA_WIDTH-1:0]     r_lo;
  logic [WORD_COUNT_WIDTH-1:0]   r_word_count;
  logic                          r_overflow;
  logic                          r_scan_done;

  logic                          w_accept;
  logic                          w_flush_push;
  logic                          w_push;
  logic [2*ADC_DATA_WIDTH-1:0]   w_push_data;
  logic                          w_push_ok;
  logic                          w_pop;

  // Raw ACQ_EN gates acceptance so a sample on the first cycle of scan-off is dropped.
  assign w_accept     = (r_state == ST_ACQ) && ACQ_EN && ADC_DATA_VALID;
  assign w_flush_push = (r_state == ST_FLUSH) && r_have_lo;
  assign w_push       = (w_accept && r_have_lo) || w_flush_push;
  assign w_push_data  = w_flush_push ? {{ADC_DATA_WIDTH{1'b0}}, r_lo} : {ADC_DATA, r_lo};
  assign w_pop        = DOUT_VALID && DOUT_READY;

  // Edge-detect flops reset high so a held ACQ_EN cannot restart a scan after reset.
  always_ff @(posedge ADC_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_acq_d1     <= 1'b1;
      r_acq_d2     <= 1'b1;
      r_have_lo    <= 1'b0;
      r_lo         <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_scan_done  <= 1'b0;
    end else begin
      r_acq_d1    <= ACQ_EN;
      r_acq_d2    <= r_acq_d1;
      r_scan_done <= 1'b0;
      if (w_push_ok && (r_word_count != '1))
        r_word_count <= r_word_count + WORD_COUNT_WIDTH'(1);
      if (w_push && !w_push_ok)
        r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (rising(r_acq_d1, r_acq_d2)) begin
            r_state      <= ST_ACQ;
            r_have_lo    <= 1'b0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        ST_ACQ: begin
          if (!r_acq_d1) r_state <= ST_FLUSH;
          if (w_accept) begin
            if (r_have_lo) begin
              r_have_lo <= 1'b0;
            end else begin
              r_lo      <= ADC_DATA;
              r_have_lo <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          r_state     <= ST_DONE;
          r_have_lo   <= 1'b0;
          r_scan_done <= 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  adc_sync_fifo #(
    .WIDTH (2*ADC_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (ADC_CLK),
    .rst_n       (RESET_N),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_push_ok   (w_push_ok),
    .o_data      (DOUT),
    .o_valid     (DOUT_VALID)
  );

  assign WORD_COUNT = r_word_count;
  assign OVERFLOW   = r_overflow;
  assign SCAN_DONE  = r_scan_done;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench: scan table, reset corner case, randomized scans against a queue model.
module tb_adc_sample_packer;
  localparam int DEPTH = 16;

  logic        ADC_CLK;
  logic        RESET_N;
  logic        ACQ_EN;
  logic [15:0] ADC_DATA;
  logic        ADC_DATA_VALID;
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic [31:0] WORD_COUNT;
  logic        OVERFLOW;
  logic        SCAN_DONE;

  adc_sample_packer #(
    .ADC_DATA_WIDTH   (16),
    .FIFO_DEPTH       (DEPTH),
    .WORD_COUNT_WIDTH (32)
  ) dut (
    .ADC_CLK        (ADC_CLK),
    .RESET_N        (RESET_N),
    .ACQ_EN         (ACQ_EN),
    .ADC_DATA       (ADC_DATA),
    .ADC_DATA_VALID (ADC_DATA_VALID),
    .DOUT           (DOUT),
    .DOUT_VALID     (DOUT_VALID),
    .DOUT_READY     (DOUT_READY),
    .WORD_COUNT     (WORD_COUNT),
    .OVERFLOW       (OVERFLOW),
    .SCAN_DONE      (SCAN_DONE)
  );

  initial begin
    ADC_CLK = 1'b0;
    forever #5 ADC_CLK = ~ADC_CLK;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: expected FIFO contents and scan bookkeeping.
  logic [31:0] mq[$];
  logic [31:0] got[$];
  bit          m_has;
  logic [15:0] m_lo;
  logic [31:0] m_wc;
  bit          m_ov;

  typedef struct {
    int          n;
    int          mode;
    bit          tail;
    logic [31:0] exp_wc;
    bit          exp_ov;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit rdy_of(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic tick(input bit acq, input bit vld, input logic [15:0] dat, input bit rdy,
                      input bit take, input bit flush, input bit clr);
    logic [31:0] word;
    bit          push;
    bit          stall;
    logic [31:0] stall_word;
    ACQ_EN = acq; ADC_DATA_VALID = vld; ADC_DATA = dat; DOUT_READY = rdy;
    #1;
    if (DOUT_VALID && rdy) got.push_back(DOUT);
    stall = DOUT_VALID && !rdy;
    stall_word = DOUT;
    push = 1'b0;
    word = '0;
    if (take) begin
      if (m_has) begin word = {dat, m_lo}; m_has = 1'b0; push = 1'b1; end
      else begin m_lo = dat; m_has = 1'b1; end
    end
    if (flush && m_has) begin word = {16'h0000, m_lo}; m_has = 1'b0; push = 1'b1; end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) begin mq.push_back(word); m_wc++; end
      else m_ov = 1'b1;
    end
    if (clr) begin m_has = 1'b0; m_wc = '0; m_ov = 1'b0; end
    @(posedge ADC_CLK);
    #1;
    cyc++;
    check($sformatf("valid@%0d", cyc), 64'(DOUT_VALID), 64'(mq.size() > 0));
    check($sformatf("dout@%0d", cyc), 64'(DOUT), 64'((mq.size() > 0) ? mq[0] : 32'h0));
    check($sformatf("wc@%0d", cyc), 64'(WORD_COUNT), 64'(m_wc));
    check($sformatf("ovf@%0d", cyc), 64'(OVERFLOW), 64'(m_ov));
    check($sformatf("done@%0d", cyc), 64'(SCAN_DONE), 64'(flush));
    if (stall) check($sformatf("stall_hold@%0d", cyc), 64'({DOUT_VALID, DOUT}), 64'({1'b1, stall_word}));
  endtask

  task automatic run_scan(input int n, input int base, input int mode, input bit tail, input bit rnd);
    int k;
    logic [15:0] d;
    k = 0;
    tick(1, 0, 16'h0, rdy_of(mode, k++), 0, 0, 0);
    tick(1, 0, 16'h0, rdy_of(mode, k++), 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      if (rnd && ($urandom_range(0, 3) == 0))
        tick(1, 0, 16'($urandom), rdy_of(mode, k++), 0, 0, 0);
      d = rnd ? 16'($urandom) : 16'(base + i);
      tick(1, 1, d, rdy_of(mode, k++), 1, 0, 0);
    end
    tick(0, tail, 16'h0055, rdy_of(mode, k++), 0, 0, 0);
    tick(0, 0, 16'h0, rdy_of(mode, k++), 0, 0, 0);
    tick(0, 0, 16'h0, rdy_of(mode, k++), 0, 1, 0);
    tick(0, 0, 16'h0, rdy_of(mode, k++), 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++)
      tick(0, 0, 16'h0, 1, 0, 0, 0);
    check("drain_empty", 64'(DOUT_VALID), 64'(0));
  endtask

  initial begin
    logic [31:0] w_first;
    logic [31:0] w_last;
    vecs[0] = '{30, 1, 1'b0, 32'd15, 1'b0, 15, 32'h0065_0064, 32'h0081_0080};
    vecs[1] = '{31, 1, 1'b0, 32'd16, 1'b0, 16, 32'h0065_0064, 32'h0000_0082};
    vecs[2] = '{40, 0, 1'b0, 32'd16, 1'b1, 16, 32'h0065_0064, 32'h0083_0082};
    vecs[3] = '{30, 2, 1'b0, 32'd15, 1'b0, 15, 32'h0065_0064, 32'h0081_0080};
    vecs[4] = '{ 4, 1, 1'b1, 32'd2,  1'b0,  2, 32'h0065_0064, 32'h0067_0066};

    m_has = 1'b0; m_lo = '0; m_wc = '0; m_ov = 1'b0;
    ACQ_EN = 1'b0; ADC_DATA = '0; ADC_DATA_VALID = 1'b0; DOUT_READY = 1'b0;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    repeat (3) @(posedge ADC_CLK);
    #2;
    check("rst_valid", 64'(DOUT_VALID), 64'(0));
    check("rst_dout", 64'(DOUT), 64'(0));
    check("rst_wc", 64'(WORD_COUNT), 64'(0));
    check("rst_ovf", 64'(OVERFLOW), 64'(0));
    check("rst_done", 64'(SCAN_DONE), 64'(0));
    @(negedge ADC_CLK);
    RESET_N = 1'b1;
    @(posedge ADC_CLK);
    #1;
    repeat (2) tick(0, 0, 16'h0, 0, 0, 0, 0);

    for (int v = 0; v < 5; v++) begin
      got.delete();
      run_scan(vecs[v].n, 100, vecs[v].mode, vecs[v].tail, 1'b0);
      check($sformatf("vec%0d_wc", v), 64'(WORD_COUNT), 64'(vecs[v].exp_wc));
      check($sformatf("vec%0d_ovf", v), 64'(OVERFLOW), 64'(vecs[v].exp_ov));
      drain();
      w_first = (got.size() > 0) ? got[0] : 32'hDEAD_BEEF;
      w_last  = (got.size() > 0) ? got[got.size()-1] : 32'hDEAD_BEEF;
      check($sformatf("vec%0d_words", v), 64'(got.size()), 64'(vecs[v].exp_words));
      check($sformatf("vec%0d_first", v), 64'(w_first), 64'(vecs[v].exp_first));
      check($sformatf("vec%0d_last", v), 64'(w_last), 64'(vecs[v].exp_last));
      for (int i = 1; i < got.size(); i++)
        if (vecs[v].mode != 0 || i < 15)
          check($sformatf("vec%0d_seq%0d", v, i), 64'(got[i]),
                64'({16'(100 + 2*i + 1), 16'(100 + 2*i)} & ((v == 1 && i == 15) ? 32'h0000_FFFF : 32'hFFFF_FFFF)));
    end

    // Reset in the middle of a scan with ACQ_EN held high.
    tick(1, 0, 16'h0, 0, 0, 0, 0);
    tick(1, 0, 16'h0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, 1, 16'(200 + i), 0, 1, 0, 0);
    RESET_N = 1'b0;
    #2;
    check("midrst_valid", 64'(DOUT_VALID), 64'(0));
    check("midrst_dout", 64'(DOUT), 64'(0));
    check("midrst_wc", 64'(WORD_COUNT), 64'(0));
    mq.delete(); m_has = 1'b0; m_wc = '0; m_ov = 1'b0;
    @(negedge ADC_CLK);
    RESET_N = 1'b1;
    @(posedge ADC_CLK);
    #1;
    for (int i = 0; i < 8; i++) tick(1, 1, 16'(300 + i), 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 16'h0, 1, 0, 0, 0);

    for (int s = 0; s < 8; s++) begin
      tick(0, 1, 16'($urandom), 1'($urandom_range(0, 1)), 0, 0, 0);
      tick(0, 1, 16'($urandom), 1'($urandom_range(0, 1)), 0, 0, 0);
      run_scan($urandom_range(0, 40), 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
